aes_decipher_block: RTL and testbench



---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_inv_sbox.sv | 45 ++++
 rtl/aes_decipher_block.sv | 124 ++++++++++++
 tb/tb_aes_decipher_block.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-length encodings, FSM states and GF(2^8) constant multipliers.
package aes_pkg;

  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 128;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [ROUND_W-1:0] AES128_ROUNDS = 4'd10;
  localparam logic [ROUND_W-1:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_INIT  = 3'd1,
    CTRL_SHIFT = 3'd2,
    CTRL_SBOX  = 3'd3,
    CTRL_MAIN  = 3'd4
  } ctrl_state_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (op[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] op);
    return gm2(op) ^ op;
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] op);
    return gm2(gm2(op));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] op);
    return gm2(gm4(op));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] op);
    return gm8(op) ^ op;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] op);
    return gm8(op) ^ gm2(op) ^ op;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ op;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ gm2(op);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box on one 32-bit word: four parallel byte substitutions.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [31:0] i_sword,
  output logic [31:0] o_new_sword
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gm2(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), built by square-and-multiply.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Undo the S-box affine transform, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
    return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  assign o_new_sword = {inv_sbox_byte(i_sword[31:24]), inv_sbox_byte(i_sword[23:16]),
                        inv_sbox_byte(i_sword[15:8]),  inv_sbox_byte(i_sword[7:0])};

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 decipher datapath; one word per cycle through a shared inverse S-box.
module aes_decipher_block
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 next,
  input  logic                 keylen,
  output logic [ROUND_W-1:0]   round,
  input  logic [BLOCK_W-1:0]   round_key,
  input  logic [BLOCK_W-1:0]   block,
  output logic [BLOCK_W-1:0]   new_block,
  output logic                 ready
);

  ctrl_state_e          r_fsm;
  logic [ROUND_W-1:0]   r_round_ctr;
  logic [1:0]           r_sword_ctr;
  logic [BLOCK_W-1:0]   r_block;
  logic                 r_ready;

  logic [WORD_W-1:0]    w_sbox_in;
  logic [WORD_W-1:0]    w_sbox_out;
  logic [BLOCK_W-1:0]   w_add_key;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
            gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = s;
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  always_comb begin
    w_sbox_in = r_block[127:96];
    case (r_sword_ctr)
      2'd0:    w_sbox_in = r_block[127:96];
      2'd1:    w_sbox_in = r_block[95:64];
      2'd2:    w_sbox_in = r_block[63:32];
      default: w_sbox_in = r_block[31:0];
    endcase
  end

  assign w_add_key = r_block ^ round_key;

  aes_inv_sbox u_inv_sbox (
    .i_sword     (w_sbox_in),
    .o_new_sword (w_sbox_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= CTRL_IDLE;
      r_round_ctr <= '0;
      r_sword_ctr <= '0;
      r_block     <= '0;
      r_ready     <= 1'b1;
    end else begin
      case (r_fsm)
        CTRL_IDLE: begin
          if (next) begin
            r_round_ctr <= (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
            r_ready     <= 1'b0;
            r_fsm       <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          r_block     <= block ^ round_key;
          r_round_ctr <= r_round_ctr - 4'd1;
          r_fsm       <= CTRL_SHIFT;
        end
        CTRL_SHIFT: begin
          r_block     <= inv_shift_rows(r_block);
          r_sword_ctr <= 2'd0;
          r_fsm       <= CTRL_SBOX;
        end
        CTRL_SBOX: begin
          case (r_sword_ctr)
            2'd0:    r_block[127:96] <= w_sbox_out;
            2'd1:    r_block[95:64]  <= w_sbox_out;
            2'd2:    r_block[63:32]  <= w_sbox_out;
            default: r_block[31:0]   <= w_sbox_out;
          endcase
          r_sword_ctr <= r_sword_ctr + 2'd1;
          if (r_sword_ctr == 2'd3) r_fsm <= CTRL_MAIN;
        end
        CTRL_MAIN: begin
          // Round key 0 closes the cipher without InvMixColumns.
          if (r_round_ctr != '0) begin
            r_block     <= inv_mix_columns(w_add_key);
            r_round_ctr <= r_round_ctr - 4'd1;
            r_fsm       <= CTRL_SHIFT;
          end else begin
            r_block <= w_add_key;
            r_ready <= 1'b1;
            r_fsm   <= CTRL_IDLE;
          end
        end
        default: r_fsm <= CTRL_IDLE;
      endcase
    end
  end

  assign round     = r_round_ctr;
  assign new_block = r_block;
  assign ready     = r_ready;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed FIPS-197 vectors, protocol and reset cases, plus encipher/decipher round trips.
module tb_aes_decipher_block;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk [16];
  logic [3:0]   rseq [$];
  int           n_checks = 0;
  int           n_errors = 0;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  // Key memory: combinational lookup of the requested round key.
  assign round_key = rk[round];

  aes_decipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[8'(x)] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255 - 32 * i -: 32];
      else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk == 8 && i % nk == 4) t = sub_word(t);
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Forward cipher reference using the current rk[] schedule.
  function automatic logic [127:0] encipher(input logic [127:0] pt, input int nr);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          t[127 - 8 * (4 * c + j) -: 8] = sbox_t[s[127 - 8 * (4 * ((c + j) % 4) + j) -: 8]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = t[127 - 8 * (4 * c + j) -: 8];
          for (int j = 0; j < 4; j++)
            t[127 - 8 * (4 * c + j) -: 8] = gmul(a[j], 8'h02) ^ gmul(a[(j + 1) % 4], 8'h03)
                                            ^ a[(j + 2) % 4] ^ a[(j + 3) % 4];
        end
      end
      s = t ^ rk[r];
    end
    return s;
  endfunction

  function automatic int round_seq_errs(input int nr);
    int bad = 0;
    if (rseq.size() != nr + 1) bad++;
    for (int i = 0; i < rseq.size() && i <= nr; i++)
      if (int'(rseq[i]) != nr - i) bad++;
    return bad;
  endfunction

  // Called at a negedge; returns at the negedge where ready is seen high again.
  task automatic run_op(input logic [127:0] blk, input logic kl, input bit disturb,
                        output logic [127:0] res, output int edges);
    block  = blk;
    keylen = kl;
    next   = 1'b1;
    @(negedge clk);
    next  = 1'b0;
    edges = 1;
    check_eq("busy_after_start", 128'(ready), 128'd0);
    rseq = {};
    rseq.push_back(round);
    while (!ready && edges < 200) begin
      if (disturb && edges == 20) begin
        next   = 1'b1;
        keylen = ~kl;
        block  = ~blk;
      end else next = 1'b0;
      @(negedge clk);
      edges++;
      if (rseq[$] != round) rseq.push_back(round);
    end
    next = 1'b0;
    res  = new_block;
  endtask

  initial begin
    logic [127:0] res, pt, ct;
    logic [255:0] key;
    logic         kl;
    int           edges, n;

    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check_eq("reset_ready", 128'(ready), 128'd1);
    check_eq("reset_round", 128'(round), 128'd0);
    check_eq("reset_new_block", new_block, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
    run_op(C1_CT, 1'b0, 1'b0, res, edges);
    check_eq("c1_result", res, C_PT);
    check_eq("c1_latency", 128'(edges), 128'd62);
    check_eq("c1_round_seq", 128'(round_seq_errs(10)), 128'd0);

    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
    run_op(C3_CT, 1'b1, 1'b0, res, edges);
    check_eq("c3_result", res, C_PT);
    check_eq("c3_latency", 128'(edges), 128'd86);
    check_eq("c3_round_seq", 128'(round_seq_errs(14)), 128'd0);

    expand_key({B_KEY, 128'h0}, 1'b0);
    run_op(B_CT, 1'b0, 1'b0, res, edges);
    check_eq("b_result", res, B_PT);
    run_op(B_CT, 1'b0, 1'b0, res, edges);
    check_eq("b_b2b_result", res, B_PT);
    check_eq("b_b2b_latency", 128'(edges), 128'd62);

    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
    run_op(C1_CT, 1'b0, 1'b1, res, edges);
    check_eq("disturb_result", res, C_PT);
    check_eq("disturb_latency", 128'(edges), 128'd62);

    // next held high across completion: ready pulses for a single cycle.
    block  = C1_CT;
    keylen = 1'b0;
    next   = 1'b1;
    @(negedge clk);
    n = 1;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    check_eq("hold_result", new_block, C_PT);
    check_eq("hold_latency", 128'(n), 128'd62);
    @(negedge clk);
    check_eq("hold_ready_one_cycle", 128'(ready), 128'd0);
    next = 1'b0;
    n = 1;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    check_eq("hold_restart_result", new_block, C_PT);
    check_eq("hold_restart_latency", 128'(n), 128'd62);

    // Reset during round 5.
    block  = C1_CT;
    keylen = 1'b0;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    n = 0;
    while (round != 4'd5 && n < 200) begin @(negedge clk); n++; end
    check_eq("rst_reached_round5", 128'(round), 128'd5);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_ready", 128'(ready), 128'd1);
    check_eq("rst_mid_round", 128'(round), 128'd0);
    check_eq("rst_mid_new_block", new_block, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(C1_CT, 1'b0, 1'b0, res, edges);
    check_eq("rst_fresh_result", res, C_PT);
    check_eq("rst_fresh_latency", 128'(edges), 128'd62);

    for (int k = 0; k < 100; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      expand_key(key, kl);
      ct = encipher(pt, kl ? 14 : 10);
      run_op(ct, kl, 1'b0, res, edges);
      check_eq("roundtrip", res, pt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
